// File: rtl/xadc_poll_defs.sv
// xadc_poll_defs: shared constants for the XADC polling sweep (channel table, states, widths).
package xadc_poll_defs;
    localparam int NCH   = 6;
    localparam int RES_W = 12;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    // Sweep order: temp, vccint, vccaux, vccbram, rfpwr_a, rfpwr_b (entry 0 in the low byte).
    localparam logic [NCH*8-1:0] DRP_TBL = {8'h1c, 8'h1b, 8'h06, 8'h02, 8'h01, 8'h00};
    typedef logic [RES_W-1:0] res_t;
    function automatic logic [7:0] drp_addr(input logic [2:0] idx);
        return DRP_TBL[idx*8 +: 8];
    endfunction
endpackage

// File: rtl/xadc_alarm_hyst.sv
// xadc_alarm_hyst: over-temperature level alarm with set/clear hysteresis, updated on a strobe.
module xadc_alarm_hyst
    import xadc_poll_defs::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  res_t i_value,
    input  res_t i_hi,
    input  res_t i_lo,
    input  logic i_upd,
    output logic o_alarm
);
    logic r_alarm;
    // Set is tested first so it wins when the thresholds are inverted.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_alarm <= 1'b0;
        else if (i_upd)
            r_alarm <= (i_value >= i_hi) ? 1'b1 : (i_value < i_lo) ? 1'b0 : r_alarm;
    assign o_alarm = r_alarm;
endmodule

// File: rtl/xadc_poll.sv
// xadc_poll: periodically sweeps six XADC channels over the DRP local bus, holds results and
// raises a hysteretic over-temperature alarm.
module xadc_poll
    import xadc_poll_defs::*;
#(
    parameter int CBUS_ADDR_WIDTH = 8,
    parameter int CBUS_DATA_WIDTH = 16,
    parameter int POLL_PERIOD     = 1000000,
    parameter int RD_WAIT         = 16
)(
    input  logic                       clk_cfg,
    input  logic                       rst_cfg_n,
    input  logic                       enable,
    input  logic                       poll_req,
    input  logic [11:0]                temp_hi_th,
    input  logic [11:0]                temp_lo_th,
    output logic [CBUS_ADDR_WIDTH-1:0] m_lbus_addr,
    output logic [CBUS_DATA_WIDTH-1:0] m_lbus_wdata,
    output logic                       m_lbus_oe,
    output logic                       m_lbus_we,
    input  logic [CBUS_DATA_WIDTH-1:0] m_lbus_rdata,
    output logic [11:0]                temp_val,
    output logic [11:0]                vccint_val,
    output logic [11:0]                vccaux_val,
    output logic [11:0]                vccbram_val,
    output logic [11:0]                rfpwr_a_val,
    output logic [11:0]                rfpwr_b_val,
    output logic                       data_vld,
    output logic                       over_temp,
    output logic                       busy
);
    localparam int CW = $clog2(POLL_PERIOD + 1);
    localparam int WW = $clog2(RD_WAIT + 1);

    logic [2:0]                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [WW-1:0]              r_wcnt;
    logic [2:0]                 r_idx;
    logic [CBUS_ADDR_WIDTH-1:0] r_addr;
    logic                       r_pend;
    res_t                       r_res [NCH];
    logic                       w_period;
    logic                       w_start;
    logic                       w_restart;
    logic                       w_done;
    logic                       w_unused;

    assign w_period  = enable && (r_cnt == CW'(POLL_PERIOD - 1));
    assign w_start   = (r_state == S_IDLE) && (poll_req || w_period);
    assign w_done    = r_state == S_DONE;
    assign w_restart = w_done && (r_pend || poll_req);
    assign w_unused  = ^m_lbus_rdata[3:0];

    always_ff @(posedge clk_cfg or negedge rst_cfg_n)
        if (!rst_cfg_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_pend  <= 1'b0;
            for (int i = 0; i < NCH; i++)
                r_res[i] <= '0;
        end else begin
            // One-deep request latch; requests during a sweep merge into it.
            r_pend <= w_restart ? 1'b0 : (r_pend || (poll_req && r_state != S_IDLE));
            case (r_state)
                S_IDLE:
                    if (w_start) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_addr  <= CBUS_ADDR_WIDTH'(drp_addr(3'd0));
                        r_state <= S_ISSUE;
                    end else
                        r_cnt <= enable ? r_cnt + 1'b1 : '0;
                S_ISSUE: begin
                    r_wcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT:
                    if (r_wcnt == WW'(RD_WAIT - 1))
                        r_state <= S_STORE;
                    else
                        r_wcnt <= r_wcnt + 1'b1;
                S_STORE: begin
                    r_res[r_idx] <= m_lbus_rdata[15:4];
                    if (r_idx == 3'(NCH - 1))
                        r_state <= S_DONE;
                    else begin
                        r_idx   <= r_idx + 3'd1;
                        r_addr  <= CBUS_ADDR_WIDTH'(drp_addr(r_idx + 3'd1));
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                    if (w_restart) begin
                        r_idx   <= '0;
                        r_addr  <= CBUS_ADDR_WIDTH'(drp_addr(3'd0));
                        r_state <= S_ISSUE;
                    end else
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end

    xadc_alarm_hyst u_alarm (
        .i_clk   (clk_cfg),
        .i_rst_n (rst_cfg_n),
        .i_value (r_res[0]),
        .i_hi    (temp_hi_th),
        .i_lo    (temp_lo_th),
        .i_upd   (w_done),
        .o_alarm (over_temp)
    );

    assign m_lbus_addr  = r_addr;
    assign m_lbus_wdata = '0;
    assign m_lbus_we    = 1'b0;
    assign m_lbus_oe    = r_state == S_ISSUE;
    assign busy         = r_state != S_IDLE;
    assign data_vld     = w_done;
    assign temp_val     = r_res[0];
    assign vccint_val   = r_res[1];
    assign vccaux_val   = r_res[2];
    assign vccbram_val  = r_res[3];
    assign rfpwr_a_val  = r_res[4];
    assign rfpwr_b_val  = r_res[5];
endmodule

// File: tb/tb_xadc_poll.sv
// tb_xadc_poll: self-checking bench for xadc_poll with a DRP slave model and result scoreboard.
module tb_xadc_poll;
    logic        clk_cfg = 1'b0;
    logic        rst_cfg_n = 1'b0;
    logic        enable = 1'b0;
    logic        poll_req = 1'b0;
    logic [11:0] temp_hi_th;
    logic [11:0] temp_lo_th;
    logic [7:0]  m_lbus_addr;
    logic [15:0] m_lbus_wdata;
    logic        m_lbus_oe;
    logic        m_lbus_we;
    logic [15:0] m_lbus_rdata;
    logic [11:0] temp_val, vccint_val, vccaux_val, vccbram_val, rfpwr_a_val, rfpwr_b_val;
    logic        data_vld;
    logic        over_temp;
    logic        busy;

    typedef struct { logic [7:0] addr; int cyc; } oe_t;
    typedef struct { logic [11:0] hi; logic [11:0] lo; logic [11:0] temp; logic ot; } vec_t;
    typedef logic [6*12-1:0] exp_t;

    logic [15:0] slv [6];
    logic [7:0]  exp_addr [6] = '{8'h00, 8'h01, 8'h02, 8'h06, 8'h1b, 8'h1c};
    oe_t         q_oe [$];
    exp_t        sb [$];
    vec_t        vt [6];
    int          cyc = 0;
    int          n_vld = 0;
    int          vld_cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    xadc_poll #(.POLL_PERIOD(64), .RD_WAIT(4)) dut (
        .clk_cfg      (clk_cfg),
        .rst_cfg_n    (rst_cfg_n),
        .enable       (enable),
        .poll_req     (poll_req),
        .temp_hi_th   (temp_hi_th),
        .temp_lo_th   (temp_lo_th),
        .m_lbus_addr  (m_lbus_addr),
        .m_lbus_wdata (m_lbus_wdata),
        .m_lbus_oe    (m_lbus_oe),
        .m_lbus_we    (m_lbus_we),
        .m_lbus_rdata (m_lbus_rdata),
        .temp_val     (temp_val),
        .vccint_val   (vccint_val),
        .vccaux_val   (vccaux_val),
        .vccbram_val  (vccbram_val),
        .rfpwr_a_val  (rfpwr_a_val),
        .rfpwr_b_val  (rfpwr_b_val),
        .data_vld     (data_vld),
        .over_temp    (over_temp),
        .busy         (busy)
    );

    always #5 clk_cfg = ~clk_cfg;

    assign m_lbus_rdata = m_lbus_addr == 8'h00 ? slv[0] :
                          m_lbus_addr == 8'h01 ? slv[1] :
                          m_lbus_addr == 8'h02 ? slv[2] :
                          m_lbus_addr == 8'h06 ? slv[3] :
                          m_lbus_addr == 8'h1b ? slv[4] :
                          m_lbus_addr == 8'h1c ? slv[5] : 16'hDEAD;

    always @(posedge clk_cfg) begin
        #1;
        cyc++;
        if (m_lbus_oe) q_oe.push_back('{m_lbus_addr, cyc});
        if (data_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic exp_t pack_exp();
        exp_t e;
        for (int i = 0; i < 6; i++) e[i*12 +: 12] = slv[i][15:4];
        return e;
    endfunction

    task automatic pulse_req();
        @(negedge clk_cfg);
        poll_req = 1'b1;
        @(negedge clk_cfg);
        poll_req = 1'b0;
    endtask

    task automatic wait_vld(input int budget);
        int start;
        start = n_vld;
        for (int i = 0; i < budget && n_vld == start; i++) @(negedge clk_cfg);
        chk("vld_arrived", 32'(n_vld != start), 1);
    endtask

    task automatic sb_check();
        exp_t e;
        logic [11:0] act [6];
        act = '{temp_val, vccint_val, vccaux_val, vccbram_val, rfpwr_a_val, rfpwr_b_val};
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        for (int i = 0; i < 6; i++) chk($sformatf("val_ch%0d", i), act[i], e[i*12 +: 12]);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int nv;
        temp_hi_th = 12'h900;
        temp_lo_th = 12'h800;
        enable = 1'b1;
        slv = '{16'hA5F0, 16'h3C7A, 16'h5DE1, 16'h6F02, 16'h7B3C, 16'h1234};
        repeat (3) @(negedge clk_cfg);
        chk("rst_oe", m_lbus_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", data_vld, 0);
        chk("rst_ot", over_temp, 0);
        chk("rst_addr", m_lbus_addr, 0);
        chk("we_zero", m_lbus_we, 0);
        chk("wdata_zero", m_lbus_wdata, 0);
        chk("rst_vals", 32'(|{temp_val, vccint_val, vccaux_val, vccbram_val, rfpwr_a_val, rfpwr_b_val}), 0);

        // Automatic sweep: timing, address order and captured values.
        sb.push_back(pack_exp());
        q_oe.delete();
        c0 = cyc;
        rst_cfg_n = 1'b1;
        wait_vld(200);
        enable = 1'b0;
        sb_check();
        chk("temp_A5F", temp_val, 12'hA5F);
        chk("rfpwr_b_123", rfpwr_b_val, 12'h123);
        chk("oe_count", q_oe.size(), 6);
        chk("first_oe_delay", q_oe.size() > 0 ? q_oe[0].cyc - c0 : -1, 64);
        for (int i = 0; i < 6; i++)
            chk($sformatf("addr%0d", i), i < q_oe.size() ? q_oe[i].addr : 8'hxx, exp_addr[i]);
        for (int i = 1; i < 6; i++)
            chk($sformatf("oe_gap%0d", i), i < q_oe.size() ? q_oe[i].cyc - q_oe[i-1].cyc : -1, 6);
        chk("vld_span", q_oe.size() > 0 ? vld_cyc - q_oe[0].cyc + 1 : -1, 37);
        @(negedge clk_cfg);
        chk("ot_A5F", over_temp, 1);

        // Hysteresis table, one requested sweep per row.
        vt[0] = '{12'h900, 12'h800, 12'h100, 1'b0};
        vt[1] = '{12'h900, 12'h800, 12'h8FF, 1'b0};
        vt[2] = '{12'h900, 12'h800, 12'h900, 1'b1};
        vt[3] = '{12'h900, 12'h800, 12'h850, 1'b1};
        vt[4] = '{12'h900, 12'h800, 12'h7FF, 1'b0};
        vt[5] = '{12'h700, 12'h900, 12'h800, 1'b1};
        for (int r = 0; r < 6; r++) begin
            temp_hi_th = vt[r].hi;
            temp_lo_th = vt[r].lo;
            slv[0] = {vt[r].temp, 4'h5};
            for (int i = 1; i < 6; i++) slv[i] = 16'($urandom);
            sb.push_back(pack_exp());
            q_oe.delete();
            pulse_req();
            wait_vld(100);
            sb_check();
            chk($sformatf("row%0d_oe_count", r), q_oe.size(), 6);
            @(negedge clk_cfg);
            chk($sformatf("row%0d_over_temp", r), over_temp, 32'(vt[r].ot));
        end

        // Two requests during a sweep merge into exactly one follow-on sweep.
        sb.push_back(pack_exp());
        sb.push_back(pack_exp());
        q_oe.delete();
        nv = n_vld;
        pulse_req();
        repeat (10) @(negedge clk_cfg);
        pulse_req();
        repeat (5) @(negedge clk_cfg);
        pulse_req();
        wait_vld(100);
        sb_check();
        @(negedge clk_cfg);
        chk("followon_oe", m_lbus_oe, 1);
        chk("followon_addr", m_lbus_addr, 8'h00);
        wait_vld(100);
        sb_check();
        repeat (300) @(negedge clk_cfg);
        chk("merge_vld_count", n_vld - nv, 2);
        chk("merge_oe_count", q_oe.size(), 12);
        chk("merge_idle", busy, 0);

        // Reset during WAIT of channel 3 aborts the sweep.
        q_oe.delete();
        pulse_req();
        for (int i = 0; i < 100 && q_oe.size() < 4; i++) @(negedge clk_cfg);
        chk("idx3_addr", q_oe.size() > 3 ? q_oe[3].addr : 8'hxx, 8'h06);
        repeat (2) @(negedge clk_cfg);
        chk("pre_rst_busy", busy, 1);
        nv = n_vld;
        #1 rst_cfg_n = 1'b0;
        #1;
        chk("arst_oe", m_lbus_oe, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", m_lbus_addr, 0);
        chk("arst_ot", over_temp, 0);
        chk("arst_vld", data_vld, 0);
        chk("arst_vals", 32'(|{temp_val, vccint_val, vccaux_val, vccbram_val, rfpwr_a_val, rfpwr_b_val}), 0);
        repeat (3) @(negedge clk_cfg);
        rst_cfg_n = 1'b1;
        repeat (60) @(negedge clk_cfg);
        chk("abort_no_vld", n_vld - nv, 0);
        chk("abort_no_oe", q_oe.size(), 4);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
